sbc_clk_rst_gen: RTL and testbench



---
 rtl/sbc_clk_rst_gen_pkg.sv | 22 ++
 rtl/sbc_clk_rst_gen_reset_sync.sv | 40 ++++
 rtl/sbc_clk_rst_gen.sv | 115 +++++++++++
 tb/tb_sbc_clk_rst_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sbc_clk_rst_gen_pkg.sv
// Shared definitions for the SBC clock/reset front end: FSM state encodings,
// default divider/NCO constants reused by sbc_system, and the phi2 phase map.
package sbc_clk_rst_gen_pkg;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_RUN   = 2'd1,
      S_HALT  = 2'd2,
      S_STEP  = 2'd3
   } sbc_state_e;

   localparam int unsigned SBC_PHI2_DIV        = 8;
   localparam int unsigned SBC_RST_PHI2_CYCLES = 16;
   localparam int unsigned SBC_ACC_W           = 16;
   localparam int unsigned SBC_BAUD_INC        = 2416;

   // phi2 is low for the first half of the phase count, high for the second
   function automatic logic phi2_level(input int unsigned cnt, input int unsigned div);
      return (cnt >= (div / 2));
   endfunction

endpackage

// File: rtl/sbc_clk_rst_gen_reset_sync.sv
// res_n synchroniser and saturating phi2-fall stretch counter; flags the
// phi2 falling edge at which the system reset may be released.
module sbc_reset_sync
   import sbc_clk_rst_gen_pkg::*;
#(
   parameter int unsigned RST_PHI2_CYCLES = SBC_RST_PHI2_CYCLES
) (
   input  logic fst_clk,
   input  logic res_n,
   input  logic fall_strobe,
   output logic release_ok
);

   localparam int unsigned     SW       = $clog2(RST_PHI2_CYCLES + 1);
   localparam logic [SW-1:0]   STR_LAST = SW'(RST_PHI2_CYCLES - 1);
   localparam logic [SW-1:0]   STR_MAX  = SW'(RST_PHI2_CYCLES);

   logic [1:0]    sync;
   logic [SW-1:0] stretch;
   logic          res_sync;

   assign res_sync = sync[1];

   always_ff @(posedge fst_clk or negedge res_n) begin
      if (!res_n) begin
         sync    <= '0;
         stretch <= '0;
      end else begin
         sync <= {sync[0], 1'b1};
         if (res_sync && fall_strobe && (stretch != STR_MAX)) begin
            stretch <= stretch + 1'b1;
         end
      end
   end

   // fall_strobe is the value about to be registered into phi2_fall, so the
   // release lands on the same edge that raises the fall strobe
   assign release_ok = res_sync & fall_strobe & (stretch == STR_LAST);

endmodule

// File: rtl/sbc_clk_rst_gen.sv
// SBC clock/reset front end: phi2 with edge strobes, NCO baud reference,
// stretched system reset and debug halt/single-step of phi2.
module sbc_clk_rst_gen
   import sbc_clk_rst_gen_pkg::*;
#(
   parameter int unsigned PHI2_DIV        = SBC_PHI2_DIV,
   parameter int unsigned RST_PHI2_CYCLES = SBC_RST_PHI2_CYCLES,
   parameter int unsigned ACC_W           = SBC_ACC_W,
   parameter int unsigned BAUD_INC        = SBC_BAUD_INC
) (
   input  logic fst_clk,
   input  logic res_n,
   input  logic halt,
   input  logic step,
   output logic phi2,
   output logic phi2_rise,
   output logic phi2_fall,
   output logic uart_clk,
   output logic sys_res_n,
   output logic halted
);

   localparam int unsigned        CNT_W    = $clog2(PHI2_DIV);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PHI2_DIV - 1);
   localparam logic [ACC_W-1:0]   ACC_INC  = ACC_W'(BAUD_INC);

   sbc_state_e       state;
   sbc_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [ACC_W-1:0] acc;
   logic             phi2_nxt;
   logic             rise_nxt;
   logic             fall_nxt;
   logic             step_d;
   logic             step_edge;
   logic             wrap;
   logic             release_ok;

   assign wrap      = (cnt == CNT_LAST);
   assign step_edge = step & ~step_d;
   assign phi2_nxt  = phi2_level(32'(cnt), PHI2_DIV);
   assign rise_nxt  = phi2_nxt & ~phi2;
   assign fall_nxt  = ~phi2_nxt & phi2;

   sbc_reset_sync #(
      .RST_PHI2_CYCLES (RST_PHI2_CYCLES)
   ) u_reset_sync (
      .fst_clk     (fst_clk),
      .res_n       (res_n),
      .fall_strobe (fall_nxt),
      .release_ok  (release_ok)
   );

   always_ff @(posedge fst_clk or negedge res_n) begin
      if (!res_n) begin
         state     <= S_RESET;
         cnt       <= '0;
         phi2      <= 1'b0;
         phi2_rise <= 1'b0;
         phi2_fall <= 1'b0;
         sys_res_n <= 1'b0;
         step_d    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         phi2      <= phi2_nxt;
         phi2_rise <= rise_nxt;
         phi2_fall <= fall_nxt;
         sys_res_n <= (state_nxt != S_RESET);
         step_d    <= step;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = wrap ? '0 : cnt + 1'b1;
      case (state)
         S_RESET: begin
            if (release_ok) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (wrap && halt) state_nxt = S_HALT;
         end
         // cnt pinned at 0 keeps phi2 low; dropping halt beats a coincident step
         S_HALT: begin
            cnt_nxt = '0;
            if (!halt) begin
               state_nxt = S_RUN;
            end else if (step_edge) begin
               state_nxt = S_STEP;
            end
         end
         S_STEP: begin
            if (wrap) state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_RESET;
         end
      endcase
   end

   // baud NCO free-runs independently of the phi2 state machine
   always_ff @(posedge fst_clk or negedge res_n) begin
      if (!res_n) begin
         acc <= '0;
      end else begin
         acc <= acc + ACC_INC;
      end
   end

   assign uart_clk = acc[ACC_W-1];
   assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_sbc_clk_rst_gen.sv
// Directed self-checking bench for sbc_clk_rst_gen with PHI2_DIV=8,
// RST_PHI2_CYCLES=4, ACC_W=16, BAUD_INC=2416.
module tb_sbc_clk_rst_gen;

   logic fst_clk = 1'b0;
   logic res_n;
   logic halt;
   logic step;
   logic phi2;
   logic phi2_rise;
   logic phi2_fall;
   logic uart_clk;
   logic sys_res_n;
   logic halted;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 fst_clk = ~fst_clk;

   sbc_clk_rst_gen #(
      .PHI2_DIV        (8),
      .RST_PHI2_CYCLES (4),
      .ACC_W           (16),
      .BAUD_INC        (2416)
   ) dut (
      .fst_clk   (fst_clk),
      .res_n     (res_n),
      .halt      (halt),
      .step      (step),
      .phi2      (phi2),
      .phi2_rise (phi2_rise),
      .phi2_fall (phi2_fall),
      .uart_clk  (uart_clk),
      .sys_res_n (sys_res_n),
      .halted    (halted)
   );

   task automatic tick();
      @(negedge fst_clk);
   endtask

   // Counts edges after res_n release until sys_res_n rises (bounded at 60).
   task automatic wait_release(output int k, output int falls, output int first_rise,
                               output logic u13, output logic u14);
      k = 0; falls = 0; first_rise = 0; u13 = 1'bx; u14 = 1'bx;
      while (k < 60) begin
         tick(); k++;
         if (phi2_fall) falls++;
         if (phi2_rise && first_rise == 0) first_rise = k;
         if (k == 13) u13 = uart_clk;
         if (k == 14) u14 = uart_clk;
         if (sys_res_n) break;
      end
   endtask

   task automatic test_reset();
      int k, falls, fr;
      logic u13, u14;
      res_n = 1'b0; halt = 1'b0; step = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({phi2, phi2_rise, phi2_fall, uart_clk, sys_res_n, halted} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_values: got %b expected 000000",
                  {phi2, phi2_rise, phi2_fall, uart_clk, sys_res_n, halted});
      end
      res_n = 1'b1;
      wait_release(k, falls, fr, u13, u14);
      n_tests++;
      if (k !== 33) begin n_fail++; $display("FAIL release_cycle: got %0d expected 33", k); end
      n_tests++;
      if (falls !== 4) begin n_fail++; $display("FAIL release_falls: got %0d expected 4", falls); end
      n_tests++;
      if (phi2_fall !== 1'b1) begin n_fail++; $display("FAIL release_coincident_fall: got %b expected 1", phi2_fall); end
      n_tests++;
      if (fr !== 5) begin n_fail++; $display("FAIL first_rise_cycle: got %0d expected 5", fr); end
      n_tests++;
      if (u13 !== 1'b0 || u14 !== 1'b1) begin
         n_fail++; $display("FAIL uart_first_rise: got %b%b expected 01", u13, u14);
      end
   endtask

   task automatic test_period();
      int k, per, hi;
      step = 1'b1; tick(); step = 1'b0;
      for (int p = 0; p < 2; p++) begin
         k = 0;
         while (!phi2_rise && k < 20) begin tick(); k++; end
         per = 0; hi = 0;
         do begin
            if (phi2) hi++;
            tick(); per++;
         end while (!phi2_rise && per < 20);
         n_tests++;
         if (per !== 8 || hi !== 4) begin
            n_fail++; $display("FAIL phi2_period: got period %0d high %0d expected 8 4", per, hi);
         end
      end
      n_tests++;
      if (halted !== 1'b0 || sys_res_n !== 1'b1) begin
         n_fail++; $display("FAIL run_after_step_ignored: got halted %b sys_res_n %b expected 0 1", halted, sys_res_n);
      end
   endtask

   task automatic test_halt();
      int k, first_h, strobes, hi, not_h;
      k = 0;
      while (!phi2_rise && k < 20) begin tick(); k++; end
      halt = 1'b1;
      k = 0; first_h = 0;
      while (!phi2_fall && k < 20) begin
         tick(); k++;
         if (halted && first_h == 0) first_h = k;
      end
      n_tests++;
      if (k !== 4) begin n_fail++; $display("FAIL halt_fall_delay: got %0d expected 4", k); end
      n_tests++;
      if (first_h !== 3) begin n_fail++; $display("FAIL halt_entry_cycle: got %0d expected 3", first_h); end
      strobes = 0; hi = 0; not_h = 0;
      repeat (30) begin
         tick();
         if (phi2_rise || phi2_fall) strobes++;
         if (phi2) hi++;
         if (!halted) not_h++;
      end
      n_tests++;
      if (strobes !== 0 || hi !== 0 || not_h !== 0) begin
         n_fail++; $display("FAIL halt_quiet: got strobes %0d high %0d unhalted %0d expected 0 0 0", strobes, hi, not_h);
      end
   endtask

   task automatic test_step();
      int rises, falls, hstep;
      step = 1'b1; tick(); step = 1'b0;
      hstep = halted;
      rises = 0; falls = 0;
      repeat (20) begin
         tick();
         if (phi2_rise) rises++;
         if (phi2_fall) falls++;
      end
      n_tests++;
      if (hstep !== 0) begin n_fail++; $display("FAIL step_halted_low: got %0d expected 0", hstep); end
      n_tests++;
      if (rises !== 1 || falls !== 1 || halted !== 1'b1) begin
         n_fail++; $display("FAIL single_step: got rises %0d falls %0d halted %b expected 1 1 1", rises, falls, halted);
      end
   endtask

   task automatic test_double_step();
      int rises, falls;
      rises = 0; falls = 0;
      for (int p = 0; p < 2; p++) begin
         step = 1'b1; tick(); step = 1'b0;
         if (phi2_rise) rises++;
         if (phi2_fall) falls++;
         repeat (19) begin
            tick();
            if (phi2_rise) rises++;
            if (phi2_fall) falls++;
         end
      end
      n_tests++;
      if (rises !== 2 || falls !== 2 || halted !== 1'b1) begin
         n_fail++; $display("FAIL double_step: got rises %0d falls %0d halted %b expected 2 2 1", rises, falls, halted);
      end
   endtask

   task automatic test_halt_vs_step();
      int rises, r1, r2, saw_h;
      halt = 1'b0; step = 1'b1; tick(); step = 1'b0;
      rises = 0; r1 = 0; r2 = 0; saw_h = halted;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (halted) saw_h = 1;
         if (phi2_rise) begin
            rises++;
            if (rises == 1) r1 = k;
            if (rises == 2) r2 = k;
         end
      end
      n_tests++;
      if (saw_h !== 0) begin n_fail++; $display("FAIL halt_vs_step_halted: got %0d expected 0", saw_h); end
      n_tests++;
      if (rises !== 5 || r1 !== 5 || r2 !== 13) begin
         n_fail++; $display("FAIL halt_vs_step_run: got rises %0d first %0d second %0d expected 5 5 13", rises, r1, r2);
      end
   endtask

   task automatic test_nco();
      int rises;
      logic prev;
      prev = uart_clk; rises = 0;
      for (int c = 1; c <= 65536; c++) begin
         tick();
         if (uart_clk && !prev) rises++;
         prev = uart_clk;
         if (c % 777 == 0) halt = ~halt;
      end
      halt = 1'b0;
      n_tests++;
      if (rises < 2415 || rises > 2417) begin
         n_fail++; $display("FAIL nco_periods: got %0d expected 2416 +/-1", rises);
      end
   endtask

   task automatic test_reset_mid_step();
      int k, falls, fr;
      logic u13, u14;
      halt = 1'b1;
      k = 0;
      while (!halted && k < 20) begin tick(); k++; end
      n_tests++;
      if (halted !== 1'b1) begin n_fail++; $display("FAIL prestep_halted: got %b expected 1", halted); end
      step = 1'b1; tick(); step = 1'b0;
      repeat (6) tick();
      n_tests++;
      if (phi2 !== 1'b1 || halted !== 1'b0) begin
         n_fail++; $display("FAIL mid_step_state: got phi2 %b halted %b expected 1 0", phi2, halted);
      end
      res_n = 1'b0;
      #1;
      n_tests++;
      if ({phi2, phi2_rise, phi2_fall, uart_clk, sys_res_n, halted} !== 6'b0) begin
         n_fail++; $display("FAIL async_abort: got %b expected 000000",
                            {phi2, phi2_rise, phi2_fall, uart_clk, sys_res_n, halted});
      end
      tick();
      res_n = 1'b1;
      wait_release(k, falls, fr, u13, u14);
      n_tests++;
      if (k !== 33 || falls !== 4) begin
         n_fail++; $display("FAIL restretch: got cycle %0d falls %0d expected 33 4", k, falls);
      end
      k = 0;
      while (!halted && k < 20) begin tick(); k++; end
      n_tests++;
      if (k !== 7) begin n_fail++; $display("FAIL halt_after_reset: got %0d expected 7", k); end
   endtask

   initial begin
      test_reset();
      test_period();
      test_halt();
      test_step();
      test_double_step();
      test_halt_vs_step();
      test_nco();
      test_reset_mid_step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
